trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter NUM_USTATUS, default 7'd0, CSR index of ustatus.
REQ-002 SHALL have parameter NUM_UEPC, default 7'd65, CSR index of uepc.
REQ-003 SHALL have parameter NUM_UCAUSE, default 7'd66, CSR index of ucause.
REQ-004 SHALL have parameter NUM_UTVAL, default 7'd67, CSR index of utval.
REQ-005 SHALL have port iCLK  in  1  clock, rising edge.
REQ-006 SHALL have port iRST  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port iExcReq  in  1  synchronous exception request, level.
REQ-008 SHALL have port iExcCause  in  32  exception cause code.
REQ-009 SHALL have port iExcPC  in  32  PC of the faulting instruction.
REQ-010 SHALL have port iExcInstr  in  32  faulting instruction word.
REQ-011 SHALL have port iIntReq  in  3  interrupt lines {external, timer, software}, level.
REQ-012 SHALL have port iUret  in  1  URET retiring, level.
REQ-013 SHALL have port iUstatus  in  32  current ustatus (bit0 UIE, bit4 UPIE).
REQ-014 SHALL have port iUie  in  32  current uie (bit0 USIE, bit4 UTIE, bit8 UEIE).
REQ-015 SHALL have port iUtvec  in  32  current utvec.
REQ-016 SHALL have port iUepc  in  32  current uepc.
REQ-017 SHALL have port oCSRWrite  out  1  CSR bank write enable.
REQ-018 SHALL have port oCSRNum  out  7  CSR index being written.
REQ-019 SHALL have port oCSRData  out  32  CSR write data.
REQ-020 SHALL have port oPCLoad  out  1  one-cycle PC redirect strobe.
REQ-021 SHALL have port oPCTarget  out  32  redirect target.
REQ-022 SHALL have port oBusy  out  1  high whenever state != IDLE; core stalls.

Function
REQ-023 SHALL implement states IDLE, W_EPC, W_CAUSE, W_TVAL, W_STAT, REDIR, R_STAT, R_REDIR; all outputs decoded from state and captured registers only (Moore).
REQ-024 SHALL sample requests only in IDLE, at the rising edge, with priority: iExcReq > external > software > timer > iUret.
REQ-025 SHALL take an interrupt only if iUstatus[0]=1 and its enable bit (iUie[8] ext, iUie[0] sw, iUie[4] timer) is 1; masked lines are ignored.
REQ-026 On acceptance, SHALL capture epc, cause, tval into internal registers and enter W_EPC (trap) or R_STAT (URET).
REQ-027 Exception capture: epc=iExcPC, cause=iExcCause, tval=iExcInstr if iExcCause=2 else iExcPC.
REQ-028 Interrupt capture: epc=iExcPC, cause=32'h80000000|code (ext 8, sw 0, timer 4), tval=0.
REQ-029 Each of W_EPC, W_CAUSE, W_TVAL, W_STAT SHALL assert oCSRWrite for exactly one cycle, with NUM_UEPC/epc, NUM_UCAUSE/cause, NUM_UTVAL/tval, NUM_USTATUS/stat respectively, advancing unconditionally in that order.
REQ-030 stat SHALL equal iUstatus sampled at acceptance with bit4 set to old bit0 and bit0 cleared.
REQ-031 REDIR SHALL assert oPCLoad for one cycle; oPCTarget={iUtvec[31:2],2'b00}, plus 4*code when iUtvec[1:0]=01 and the trap is an interrupt; then IDLE.
REQ-032 R_STAT SHALL write NUM_USTATUS with iUstatus having bit0 set to bit4 and bit4 set to 1; R_REDIR SHALL pulse oPCLoad with oPCTarget=iUepc; then IDLE.
REQ-033 Trap latency SHALL be exactly 5 busy cycles after acceptance; URET latency exactly 2.
REQ-034 Requests arriving while oBusy=1 SHALL be ignored (not queued); still-asserted levels are re-evaluated in IDLE.
REQ-035 When not writing, oCSRWrite=0, oCSRNum=0, oCSRData=0; when not redirecting, oPCLoad=0, oPCTarget=0.

Reset
REQ-036 iRST SHALL asynchronously force IDLE, clear captured registers, and drive all outputs to 0.
REQ-037 Reset mid-sequence SHALL abort with no further CSR write or PC redirect after iRST deasserts.

Verification
REQ-038 iExcReq=1, cause=2, PC=0x100, instr=0xFFFFFFFF, utvec=0x400 -> writes 65<=0x100, 66<=2, 67<=0xFFFFFFFF, 0<=ustatus', then oPCLoad with target 0x400.
REQ-039 Timer int, ustatus=1, uie=0x10, utvec=0x401, PC=0x200 -> 66<=0x80000004, 67<=0, 0<=0x10, target 0x410.
REQ-040 iExcReq and external int together -> exception taken; interrupt ignored while oBusy=1.
REQ-041 Interrupt with ustatus[0]=0 -> no writes, oBusy stays 0.
REQ-042 iUret, ustatus=0x10, uepc=0x204 -> write 0<=0x11, then target 0x204, 2 busy cycles.
REQ-043 iRST asserted during W_CAUSE -> outputs 0 immediately; no W_TVAL/W_STAT writes after release.

Source files
------------

// File: rtl/trap_sequencer.sv
// Trap and URET sequencer: walks the user-mode CSR writes for a trap or URET one per cycle,
// then issues a single PC redirect. Outputs are decoded from state and captured registers.
module trap_sequencer #(
    parameter logic [6:0] NUM_USTATUS = 7'd0,
    parameter logic [6:0] NUM_UEPC    = 7'd65,
    parameter logic [6:0] NUM_UCAUSE  = 7'd66,
    parameter logic [6:0] NUM_UTVAL   = 7'd67
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iExcReq,
    input  logic [31:0] iExcCause,
    input  logic [31:0] iExcPC,
    input  logic [31:0] iExcInstr,
    input  logic [2:0]  iIntReq,
    input  logic        iUret,
    input  logic [31:0] iUstatus,
    input  logic [31:0] iUie,
    input  logic [31:0] iUtvec,
    input  logic [31:0] iUepc,
    output logic        oCSRWrite,
    output logic [6:0]  oCSRNum,
    output logic [31:0] oCSRData,
    output logic        oPCLoad,
    output logic [31:0] oPCTarget,
    output logic        oBusy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] W_EPC   = 3'd1;
    localparam logic [2:0] W_CAUSE = 3'd2;
    localparam logic [2:0] W_TVAL  = 3'd3;
    localparam logic [2:0] W_STAT  = 3'd4;
    localparam logic [2:0] REDIR   = 3'd5;
    localparam logic [2:0] R_STAT  = 3'd6;
    localparam logic [2:0] R_REDIR = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] stat_q, stat_d;
    logic [31:0] target_q, target_d;

    logic        ext_take, sw_take, tmr_take, int_take;
    logic [4:0]  int_code;
    logic [31:0] trap_target, trap_stat, uret_stat;

    // Only uie bits 0/4/8 are defined enables.
    logic unused_uie;
    assign unused_uie = ^{iUie[31:9], iUie[7:5], iUie[3:1]};

    always_comb begin
        ext_take = iUstatus[0] & iIntReq[2] & iUie[8];
        sw_take  = iUstatus[0] & iIntReq[0] & iUie[0];
        tmr_take = iUstatus[0] & iIntReq[1] & iUie[4];
        int_take = ext_take | sw_take | tmr_take;
        if (ext_take) begin
            int_code = 5'd8;
        end else if (sw_take) begin
            int_code = 5'd0;
        end else begin
            int_code = 5'd4;
        end
        // Vectored mode offsets only interrupts, never synchronous exceptions.
        trap_target = {iUtvec[31:2], 2'b00};
        if (!iExcReq && int_take && iUtvec[1:0] == 2'b01) begin
            trap_target = trap_target + {25'd0, int_code, 2'b00};
        end
        trap_stat = {iUstatus[31:5], iUstatus[0], iUstatus[3:1], 1'b0};
        uret_stat = {iUstatus[31:5], 1'b1, iUstatus[3:1], iUstatus[4]};
    end

    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        tval_d   = tval_q;
        stat_d   = stat_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (iExcReq) begin
                    epc_d    = iExcPC;
                    cause_d  = iExcCause;
                    tval_d   = (iExcCause == 32'd2) ? iExcInstr : iExcPC;
                    stat_d   = trap_stat;
                    target_d = trap_target;
                    state_d  = W_EPC;
                end else if (int_take) begin
                    epc_d    = iExcPC;
                    cause_d  = {1'b1, 26'd0, int_code};
                    tval_d   = 32'd0;
                    stat_d   = trap_stat;
                    target_d = trap_target;
                    state_d  = W_EPC;
                end else if (iUret) begin
                    stat_d   = uret_stat;
                    target_d = iUepc;
                    state_d  = R_STAT;
                end
            end
            W_EPC:   state_d = W_CAUSE;
            W_CAUSE: state_d = W_TVAL;
            W_TVAL:  state_d = W_STAT;
            W_STAT:  state_d = REDIR;
            REDIR:   state_d = IDLE;
            R_STAT:  state_d = R_REDIR;
            R_REDIR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= IDLE;
            epc_q    <= 32'd0;
            cause_q  <= 32'd0;
            tval_q   <= 32'd0;
            stat_q   <= 32'd0;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            tval_q   <= tval_d;
            stat_q   <= stat_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        oCSRWrite = 1'b0;
        oCSRNum   = 7'd0;
        oCSRData  = 32'd0;
        oPCLoad   = 1'b0;
        oPCTarget = 32'd0;
        oBusy     = (state_q != IDLE);
        case (state_q)
            W_EPC: begin
                oCSRWrite = 1'b1;
                oCSRNum   = NUM_UEPC;
                oCSRData  = epc_q;
            end
            W_CAUSE: begin
                oCSRWrite = 1'b1;
                oCSRNum   = NUM_UCAUSE;
                oCSRData  = cause_q;
            end
            W_TVAL: begin
                oCSRWrite = 1'b1;
                oCSRNum   = NUM_UTVAL;
                oCSRData  = tval_q;
            end
            W_STAT, R_STAT: begin
                oCSRWrite = 1'b1;
                oCSRNum   = NUM_USTATUS;
                oCSRData  = stat_q;
            end
            REDIR, R_REDIR: begin
                oPCLoad   = 1'b1;
                oPCTarget = target_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus random requests, each checked cycle by
// cycle against a transaction-level model of the expected CSR writes and redirect.
module tb_trap_sequencer;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iExcReq = 1'b0;
    logic [31:0] iExcCause = '0;
    logic [31:0] iExcPC = '0;
    logic [31:0] iExcInstr = '0;
    logic [2:0]  iIntReq = '0;
    logic        iUret = 1'b0;
    logic [31:0] iUstatus = '0;
    logic [31:0] iUie = '0;
    logic [31:0] iUtvec = '0;
    logic [31:0] iUepc = '0;
    logic        oCSRWrite;
    logic [6:0]  oCSRNum;
    logic [31:0] oCSRData;
    logic        oPCLoad;
    logic [31:0] oPCTarget;
    logic        oBusy;

    int checks = 0;
    int failures = 0;

    trap_sequencer dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iExcReq   (iExcReq),
        .iExcCause (iExcCause),
        .iExcPC    (iExcPC),
        .iExcInstr (iExcInstr),
        .iIntReq   (iIntReq),
        .iUret     (iUret),
        .iUstatus  (iUstatus),
        .iUie      (iUie),
        .iUtvec    (iUtvec),
        .iUepc     (iUepc),
        .oCSRWrite (oCSRWrite),
        .oCSRNum   (oCSRNum),
        .oCSRData  (oCSRData),
        .oPCLoad   (oPCLoad),
        .oPCTarget (oPCTarget),
        .oBusy     (oBusy)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ctrl packs {busy, csr_write, pc_load, csr_num}
    task automatic check_cycle(input string tag, input logic busy, input logic wr,
                               input logic [6:0] num, input logic [31:0] data,
                               input logic ld, input logic [31:0] tgt);
        check({tag, "_ctrl"}, 32'({oBusy, oCSRWrite, oPCLoad, oCSRNum}),
              32'({busy, wr, ld, num}));
        check({tag, "_data"}, oCSRData, data);
        check({tag, "_tgt"}, oPCTarget, tgt);
    endtask

    task automatic clear_reqs();
        iExcReq = 1'b0;
        iIntReq = 3'b000;
        iUret   = 1'b0;
    endtask

    // hold: 0 drop requests after acceptance, 1 keep them asserted, 2 random noise while busy
    task automatic do_req(input string tag, input logic exc, input logic [31:0] cause,
                          input logic [31:0] pc, input logic [31:0] instr,
                          input logic [2:0] intr, input logic uret,
                          input logic [31:0] ust, input logic [31:0] uie,
                          input logic [31:0] tvec, input logic [31:0] uepc, input int hold);
        int          kind;
        int          code;
        logic        is_int;
        logic [6:0]  w_num[4];
        logic [31:0] w_dat[4];
        logic [31:0] tgt;
        logic [31:0] stat;
        int          n;
        iExcReq = exc;  iExcCause = cause; iExcPC = pc; iExcInstr = instr;
        iIntReq = intr; iUret = uret; iUstatus = ust; iUie = uie; iUtvec = tvec; iUepc = uepc;

        // Reference: priority exc > ext > sw > timer > uret; interrupts need UIE and enable.
        kind = 0; code = 0; is_int = 1'b0;
        if (exc) begin
            kind = 1;
        end else if (ust[0] && intr[2] && uie[8]) begin
            kind = 1; is_int = 1'b1; code = 8;
        end else if (ust[0] && intr[0] && uie[0]) begin
            kind = 1; is_int = 1'b1; code = 0;
        end else if (ust[0] && intr[1] && uie[4]) begin
            kind = 1; is_int = 1'b1; code = 4;
        end else if (uret) begin
            kind = 2;
        end
        if (kind == 1) begin
            stat = (ust & ~32'h11) | (ust[0] ? 32'h10 : 32'h0);
            w_num[0] = 7'd65; w_dat[0] = pc;
            w_num[1] = 7'd66; w_dat[1] = is_int ? (32'h8000_0000 | code) : cause;
            w_num[2] = 7'd67; w_dat[2] = is_int ? 32'd0 : ((cause == 32'd2) ? instr : pc);
            w_num[3] = 7'd0;  w_dat[3] = stat;
            tgt = (tvec & ~32'h3) + ((is_int && tvec[1:0] == 2'b01) ? 32'(4 * code) : 32'd0);
            n = 5;
        end else if (kind == 2) begin
            stat = (ust & ~32'h11) | 32'h10 | (ust[4] ? 32'h1 : 32'h0);
            w_num[0] = 7'd0; w_dat[0] = stat;
            tgt = uepc;
            n = 2;
        end else begin
            n = 0;
            tgt = 32'd0;
        end

        @(posedge iCLK);
        @(negedge iCLK);
        if (n == 0) begin
            check_cycle({tag, "_none"}, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0);
            clear_reqs();
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                check_cycle($sformatf("%s_c%0d", tag, i), 1'b1, 1'b0, 7'd0, 32'd0, 1'b1, tgt);
                clear_reqs();
            end else begin
                check_cycle($sformatf("%s_c%0d", tag, i), 1'b1, 1'b1, w_num[i], w_dat[i],
                            1'b0, 32'd0);
                if (hold == 0) begin
                    clear_reqs();
                end else if (hold == 2) begin
                    iExcReq = 1'($urandom);
                    iIntReq = 3'($urandom);
                    iUret   = 1'($urandom);
                end
            end
            @(negedge iCLK);
        end
        check_cycle({tag, "_idle"}, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        #1 iRST = 1'b1;
        #2 check_cycle("reset", 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0);
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);

        do_req("exc_illegal", 1'b1, 32'd2, 32'h100, 32'hFFFF_FFFF, 3'b000, 1'b0,
               32'h1, 32'h0, 32'h400, 32'h0, 0);
        do_req("timer_vec", 1'b0, 32'd0, 32'h200, 32'h0, 3'b010, 1'b0,
               32'h1, 32'h10, 32'h401, 32'h0, 0);
        do_req("exc_over_ext", 1'b1, 32'd5, 32'h300, 32'h1234_5678, 3'b100, 1'b0,
               32'h1, 32'h100, 32'h801, 32'h0, 1);
        do_req("masked_uie0", 1'b0, 32'd0, 32'h340, 32'h0, 3'b111, 1'b0,
               32'h0, 32'h111, 32'h401, 32'h0, 0);
        do_req("uret", 1'b0, 32'd0, 32'h0, 32'h0, 3'b000, 1'b1,
               32'h10, 32'h0, 32'h400, 32'h204, 0);
        do_req("sw_over_timer", 1'b0, 32'd0, 32'h500, 32'h0, 3'b011, 1'b1,
               32'h1, 32'h11, 32'h1001, 32'h0, 0);

        // Reset during W_CAUSE aborts the sequence with no later writes or redirects.
        iExcReq = 1'b1; iExcCause = 32'd7; iExcPC = 32'h600; iUtvec = 32'h400; iUstatus = 32'h1;
        @(posedge iCLK);
        @(negedge iCLK);
        check_cycle("rst_mid_epc", 1'b1, 1'b1, 7'd65, 32'h600, 1'b0, 32'd0);
        clear_reqs();
        @(negedge iCLK);
        check_cycle("rst_mid_cause", 1'b1, 1'b1, 7'd66, 32'd7, 1'b0, 32'd0);
        #1 iRST = 1'b1;
        #1 check_cycle("rst_mid_async", 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge iCLK);
            check_cycle($sformatf("rst_after%0d", i), 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0);
        end

        for (int t = 0; t < 80; t++) begin
            do_req($sformatf("rnd%0d", t), ($urandom_range(0, 2) == 0),
                   32'($urandom_range(0, 15)), $urandom, $urandom, 3'($urandom),
                   1'($urandom), $urandom, $urandom, $urandom, $urandom, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
